reg_read_scoreboard: RTL and testbench
======================================

Name: reg_read_scoreboard

Overview:
- Issue-stage hazard unit. It is the read-side companion of the write-destination decoder.
- Decodes the source registers each incoming instruction reads.
- Tracks every register with an in-flight write in a 32-entry busy scoreboard; bits are set at issue and cleared at writeback.
- Holds issue (stall) until all sources and the destination are free.
- Sits between fetch/decode and the execute pipeline. Also exports the busy mask, an outstanding-write count and a stall-cycle counter.

Parameters:
- NUM_REGS, 32, architectural registers tracked; must be 32 to match 5-bit register fields.
- STALL_CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- issue_valid  input  1  decode presents an instruction.
- issue_instr  input  32  instruction; type field is [31:27], encoded with the `INSTR_* defines from arch_defines.v.
- issue_ready  output  1  no hazard; the instruction may issue this cycle.
- issue_fire  output  1  issue_valid && issue_ready.
- wb_valid  input  1  writeback completes this cycle.
- wb_reg  input  5  register being written back.
- flush  input  1  pipeline flush; discard all pending writes.
- busy_mask  output  32  bit r = 1 while a write to r is outstanding.
- pending_count  output  6  number of set busy bits (0..32).
- stall_cycles  output  STALL_CNT_W  cycles with issue_valid && !issue_ready.
- wb_err  output  1  sticky; writeback seen for a non-busy register.

Behaviour:
- Source decode (combinational, by type):
  - `INSTR_ALU_OP reads [26:22] and [21:17]; writes [16:12].
  - `INSTR_LOAD reads [26:22] (address); writes [21:17].
  - `INSTR_STORE reads [26:22] (address) and [21:17] (data); no write.
  - `INSTR_LOAD_IMMEDIATE reads nothing; writes [10:6].
  - Branch/jump types read [26:22]; no write.
  - All other types read and write nothing.
- Hazard is any of:
  - RAW: any read register has its busy bit set.
  - WAW: the write register has its busy bit set.
- issue_ready = !hazard, evaluated against the registered busy_mask only. There is no same-cycle writeback bypass: a writeback to R in cycle t releases a hazard on R in cycle t+1.
- issue_ready is independent of issue_valid. Decode must not change issue_instr while issue_valid && !issue_ready.
- Scoreboard update at each clock edge, in priority order:
  - flush: busy_mask <= 0, pending_count <= 0. Any issue or wb in the same cycle is ignored.
  - Otherwise, if wb_valid and busy[wb_reg]: clear busy[wb_reg].
  - Otherwise, if wb_valid and !busy[wb_reg]: no change; wb_err <= 1.
  - Independently, if issue_fire and the type writes: set busy[dest].
- Set and clear of the same register cannot collide, because WAW blocks issue while the bit is set.
- pending_count is updated incrementally: +1 on a set, -1 on a clear, net 0 for both. It must always equal popcount(busy_mask); the bench checks this every cycle.
- stall_cycles increments when issue_valid && !issue_ready, saturating at all-ones. flush does not clear it.
- wb_err is cleared only by rst.
- Register 0 is tracked like any other register.
- rst (asynchronous, any time, including mid-stall):
  - busy_mask = 0, pending_count = 0, stall_cycles = 0, wb_err = 0.
  - Hence issue_ready = 1 and issue_fire = issue_valid.
- Latency: busy bit visible 1 cycle after issue_fire; clear visible 1 cycle after wb_valid.

Test Plan:
- Reset, then LOAD_IMMEDIATE writing r5 with issue_valid=1 → issue_fire=1. Next cycle busy_mask=0x00000020, pending_count=1.
- With r5 busy, ALU_OP reading r5,r1 writing r7 → issue_ready=0; stall_cycles counts 3 over 3 cycles. wb_valid, wb_reg=5 in cycle t → ready still 0 in t, 1 in t+1. The ALU op then issues and busy_mask=0x00000080.
- WAW: r9 busy, LOAD_IMMEDIATE writing r9 → stalled until r9 writeback. STORE reading r2,r3 with both idle → issues immediately, busy_mask unchanged.
- Set 4 busy bits (r1,r2,r3,r4; pending_count=4). Assert flush together with issue of an ALU op writing r10 and wb_reg=1 → next cycle busy_mask=0, pending_count=0, r10 not set.
- wb_valid for idle r12 → wb_err=1, remaining set after further traffic until rst. Asserting rst asynchronously mid-stall → outputs zero immediately, issue_ready=1.
- Force stall_cycles near all-ones (STALL_CNT_W=4 build): hold a stall 20 cycles → counter saturates at 15.

Source files
------------

// File: rtl/reg_read_scoreboard.sv
// rtl/reg_read_scoreboard.sv - issue-stage read/write hazard scoreboard
//
// Purpose: decodes the registers an incoming instruction reads and writes.
// It holds issue while any of those registers has an outstanding write,
// and tracks in-flight writes in a 32-entry busy scoreboard. Busy bits are
// set at issue and cleared at writeback.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   issue_valid       decode presents issue_instr
//   issue_instr[31:0] instruction, type field in [31:27]
//   issue_ready       no RAW/WAW hazard against the registered busy mask
//   issue_fire        issue_valid && issue_ready
//   wb_valid, wb_reg  writeback of wb_reg completes this cycle
//   flush             discard every outstanding write
//   busy_mask         bit r set while a write to r is outstanding
//   pending_count     popcount of busy_mask, maintained incrementally
//   stall_cycles      saturating count of issue_valid && !issue_ready cycles
//   wb_err            sticky: writeback seen for a register that was not busy

`ifndef INSTR_ALU_OP
`define INSTR_ALU_OP         5'h01
`endif
`ifndef INSTR_LOAD
`define INSTR_LOAD           5'h02
`endif
`ifndef INSTR_STORE
`define INSTR_STORE          5'h03
`endif
`ifndef INSTR_LOAD_IMMEDIATE
`define INSTR_LOAD_IMMEDIATE 5'h04
`endif
`ifndef INSTR_BRANCH
`define INSTR_BRANCH         5'h05
`endif
`ifndef INSTR_JUMP
`define INSTR_JUMP           5'h06
`endif

module reg_read_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [31:0]            issue_instr,
  output logic                   issue_ready,
  output logic                   issue_fire,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_reg,
  input  logic                   flush,
  output logic [NUM_REGS-1:0]    busy_mask,
  output logic [5:0]             pending_count,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   wb_err
);

  logic       rd_a_en, rd_b_en, wr_en;
  logic [4:0] rd_a, rd_b, wr_reg;
  logic       hazard;
  logic       set_bit, clr_bit, bad_wb, stall;
  logic [NUM_REGS-1:0] set_vec, clr_vec;

  // The low six bits never carry a register field for any type.
  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, issue_instr[5:0]};

  always_comb begin
    rd_a_en = 1'b0;
    rd_b_en = 1'b0;
    wr_en   = 1'b0;
    rd_a    = issue_instr[26:22];
    rd_b    = issue_instr[21:17];
    wr_reg  = issue_instr[16:12];
    case (issue_instr[31:27])
      `INSTR_ALU_OP: begin
        rd_a_en = 1'b1;
        rd_b_en = 1'b1;
        wr_en   = 1'b1;
      end
      `INSTR_LOAD: begin
        rd_a_en = 1'b1;
        wr_en   = 1'b1;
        wr_reg  = issue_instr[21:17];
      end
      `INSTR_STORE: begin
        rd_a_en = 1'b1;
        rd_b_en = 1'b1;
      end
      `INSTR_LOAD_IMMEDIATE: begin
        wr_en  = 1'b1;
        wr_reg = issue_instr[10:6];
      end
      `INSTR_BRANCH, `INSTR_JUMP: begin
        rd_a_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Hazards use only the registered mask: a writeback releases its register
  // one cycle later, which keeps the ready path short.
  assign hazard = (rd_a_en && busy_mask[rd_a])
               || (rd_b_en && busy_mask[rd_b])
               || (wr_en   && busy_mask[wr_reg]);

  assign issue_ready = !hazard;
  assign issue_fire  = issue_valid && issue_ready;
  assign stall       = issue_valid && !issue_ready;

  assign set_bit = issue_fire && wr_en;
  assign clr_bit = wb_valid && busy_mask[wb_reg];
  assign bad_wb  = wb_valid && !busy_mask[wb_reg];
  assign set_vec = set_bit ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << wr_reg) : '0;
  assign clr_vec = clr_bit ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << wb_reg) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_mask     <= '0;
      pending_count <= 6'd0;
      wb_err        <= 1'b0;
    end else if (flush) begin
      busy_mask     <= '0;
      pending_count <= 6'd0;
    end else begin
      // Set and clear never hit the same register: WAW blocks that issue.
      busy_mask <= (busy_mask & ~clr_vec) | set_vec;
      case ({set_bit, clr_bit})
        2'b10:   pending_count <= pending_count + 6'd1;
        2'b01:   pending_count <= pending_count - 6'd1;
        default: pending_count <= pending_count;
      endcase
      if (bad_wb) wb_err <= 1'b1;
    end
  end

  // Stall statistics survive flush; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_reg_read_scoreboard.sv
// tb/tb_reg_read_scoreboard.sv - self-checking bench for reg_read_scoreboard

`ifndef INSTR_ALU_OP
`define INSTR_ALU_OP         5'h01
`endif
`ifndef INSTR_LOAD
`define INSTR_LOAD           5'h02
`endif
`ifndef INSTR_STORE
`define INSTR_STORE          5'h03
`endif
`ifndef INSTR_LOAD_IMMEDIATE
`define INSTR_LOAD_IMMEDIATE 5'h04
`endif
`ifndef INSTR_BRANCH
`define INSTR_BRANCH         5'h05
`endif
`ifndef INSTR_JUMP
`define INSTR_JUMP           5'h06
`endif

module tb_reg_read_scoreboard;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0;
  logic [31:0]   issue_instr = 32'd0;
  logic          issue_ready, issue_fire;
  logic          wb_valid = 1'b0;
  logic [4:0]    wb_reg = 5'd0;
  logic          flush = 1'b0;
  logic [31:0]   busy_mask;
  logic [5:0]    pending_count;
  logic [SW-1:0] stall_cycles;
  logic          wb_err;

  int checks = 0;
  int errors = 0;

  reg_read_scoreboard #(.NUM_REGS(32), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_instr(issue_instr),
    .issue_ready(issue_ready), .issue_fire(issue_fire),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush),
    .busy_mask(busy_mask), .pending_count(pending_count),
    .stall_cycles(stall_cycles), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu(input int a, input int b, input int d);
    return {`INSTR_ALU_OP, 5'(a), 5'(b), 5'(d), 12'd0};
  endfunction
  function automatic logic [31:0] st(input int a, input int d);
    return {`INSTR_STORE, 5'(a), 5'(d), 17'd0};
  endfunction
  function automatic logic [31:0] li(input int d);
    return {`INSTR_LOAD_IMMEDIATE, 16'd0, 5'(d), 6'd0};
  endfunction

  // Model: set of busy registers, error flag, stall count.
  bit m_busy[32];
  bit m_err;
  int m_stall;

  // Registers read / written by an instruction, straight from the type table.
  task automatic regs_of(input logic [31:0] i, output int reads[$], output int dest);
    reads = {};
    dest  = -1;
    case (i[31:27])
      `INSTR_ALU_OP:         begin reads = {int'(i[26:22]), int'(i[21:17])}; dest = int'(i[16:12]); end
      `INSTR_LOAD:           begin reads = {int'(i[26:22])}; dest = int'(i[21:17]); end
      `INSTR_STORE:          reads = {int'(i[26:22]), int'(i[21:17])};
      `INSTR_LOAD_IMMEDIATE: dest = int'(i[10:6]);
      `INSTR_BRANCH, `INSTR_JUMP: reads = {int'(i[26:22])};
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    int reads[$];
    int dest;
    bit ready, fire;
    logic [31:0] mask;
    int cnt;
    if (rst) begin
      foreach (m_busy[r]) m_busy[r] = 1'b0;
      m_err = 1'b0;
      m_stall = 0;
    end
    regs_of(issue_instr, reads, dest);
    ready = 1'b1;
    foreach (reads[k]) if (m_busy[reads[k]]) ready = 1'b0;
    if (dest >= 0 && m_busy[dest]) ready = 1'b0;
    fire = issue_valid && ready;
    mask = 32'd0;
    cnt = 0;
    for (int r = 0; r < 32; r++) if (m_busy[r]) begin mask[r] = 1'b1; cnt++; end
    chk("issue_ready", 32'(issue_ready), 32'(ready));
    chk("issue_fire", 32'(issue_fire), 32'(fire));
    chk("busy_mask", busy_mask, mask);
    chk("pending_count", 32'(pending_count), 32'(cnt));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    chk("wb_err", 32'(wb_err), 32'(m_err));
    if (!rst) begin
      if (issue_valid && !ready && m_stall < 15) m_stall++;
      if (flush) begin
        foreach (m_busy[r]) m_busy[r] = 1'b0;
      end else begin
        if (wb_valid) begin
          if (m_busy[wb_reg]) m_busy[wb_reg] = 1'b0;
          else m_err = 1'b1;
        end
        if (fire && dest >= 0) m_busy[dest] = 1'b1;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] i);
    issue_valid = 1'b1;
    issue_instr = i;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic wb(input int r);
    wb_valid = 1'b1;
    wb_reg = 5'(r);
    step();
    wb_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] saved;
    step(2);
    rst = 1'b0;
    #1;
    chk("lit_reset_busy", busy_mask, 32'h0);
    chk("lit_reset_ready", 32'(issue_ready), 32'd1);

    // LOAD_IMMEDIATE r5
    issue_valid = 1'b1; issue_instr = li(5); #1;
    chk("lit_li5_fire", 32'(issue_fire), 32'd1);
    step(); issue_valid = 1'b0; #1;
    chk("lit_li5_busy", busy_mask, 32'h0000_0020);
    chk("lit_li5_count", 32'(pending_count), 32'd1);

    // RAW on r5, release by writeback without same-cycle bypass
    issue_valid = 1'b1; issue_instr = alu(5, 1, 7); #1;
    chk("lit_raw_ready", 32'(issue_ready), 32'd0);
    step(3);
    chk("lit_stall3", 32'(stall_cycles), 32'd3);
    wb_valid = 1'b1; wb_reg = 5'd5; #1;
    chk("lit_wb_same_cycle", 32'(issue_ready), 32'd0);
    step(); wb_valid = 1'b0; #1;
    chk("lit_wb_next_cycle", 32'(issue_ready), 32'd1);
    step(); issue_valid = 1'b0; #1;
    chk("lit_alu_busy", busy_mask, 32'h0000_0080);

    // WAW on r9
    issue(li(9));
    issue_valid = 1'b1; issue_instr = li(9); #1;
    chk("lit_waw_ready", 32'(issue_ready), 32'd0);
    step(2);
    wb_valid = 1'b1; wb_reg = 5'd9;
    step(); wb_valid = 1'b0;
    step(); issue_valid = 1'b0;
    saved = busy_mask;
    issue_valid = 1'b1; issue_instr = st(2, 3); #1;
    chk("lit_store_fire", 32'(issue_fire), 32'd1);
    step(); issue_valid = 1'b0; #1;
    chk("lit_store_mask", busy_mask, saved);
    wb(7);
    wb(9);

    // flush beats same-cycle issue and writeback
    for (int r = 1; r <= 4; r++) issue(li(r));
    chk("lit_four_busy", 32'(pending_count), 32'd4);
    flush = 1'b1; issue_valid = 1'b1; issue_instr = alu(11, 12, 10);
    wb_valid = 1'b1; wb_reg = 5'd1;
    step();
    flush = 1'b0; issue_valid = 1'b0; wb_valid = 1'b0; #1;
    chk("lit_flush_mask", busy_mask, 32'h0);
    chk("lit_flush_count", 32'(pending_count), 32'd0);

    // spurious writeback is sticky
    wb(12);
    chk("lit_wb_err", 32'(wb_err), 32'd1);
    issue(li(6));
    wb(6);
    issue(li(0));
    wb(0);
    chk("lit_wb_err_sticky", 32'(wb_err), 32'd1);

    // asynchronous reset in the middle of a stall
    issue(li(6));
    issue_valid = 1'b1; issue_instr = alu(6, 0, 8);
    step(2);
    #2 rst = 1'b1; #1;
    chk("lit_rst_busy", busy_mask, 32'h0);
    chk("lit_rst_stall", 32'(stall_cycles), 32'd0);
    chk("lit_rst_err", 32'(wb_err), 32'd0);
    chk("lit_rst_ready", 32'(issue_ready), 32'd1);
    chk("lit_rst_fire", 32'(issue_fire), 32'd1);
    issue_valid = 1'b0;
    step();
    rst = 1'b0;

    // saturation of the 4-bit stall counter
    issue(li(20));
    issue_valid = 1'b1; issue_instr = alu(20, 21, 22);
    step(20);
    chk("lit_stall_sat", 32'(stall_cycles), 32'd15);
    issue_valid = 1'b0;
    wb(20);
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
